// File: rtl/jtag_bus_bridge_pkg.sv
// rtl/jtag_bus_bridge_pkg.sv - shared types, defaults and helpers for the debug bus bridge
package jtag_bus_bridge_pkg;

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_DATA_W  = 32;
  localparam int DEF_TIMEOUT = 255;
  localparam int DEF_TO_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HOLD = 3'd1,
    ST_REQ  = 3'd2,
    ST_WAIT = 3'd3,
    ST_RESP = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_BUS      = 2'd3
  } err_code_e;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/jtag_bus_bridge_if.sv
// rtl/jtag_bus_bridge_if.sv - DM request/response, core stall and system-bus signals
interface jtag_bus_bridge_if
  import jtag_bus_bridge_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              dbg_req_valid_i;
  logic              dbg_req_ready_o;
  logic              dbg_we_i;
  logic [ADDR_W-1:0] dbg_addr_i;
  logic [DATA_W-1:0] dbg_wdata_i;
  logic              dbg_resp_valid_o;
  logic              dbg_resp_ready_i;
  logic [DATA_W-1:0] dbg_resp_rdata_o;
  logic              dbg_resp_err_o;
  logic              core_hold_o;
  logic              core_idle_i;
  logic              bus_req_o;
  logic              bus_gnt_i;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_rvalid_i;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              bus_err_i;

  // Bridge side
  modport slave (
    input  dbg_req_valid_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_resp_ready_i,
    input  core_idle_i, bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    output dbg_req_ready_o, dbg_resp_valid_o, dbg_resp_rdata_o, dbg_resp_err_o,
    output core_hold_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
  );

  // Environment side: debug module, core and bus arbiter
  modport master (
    output dbg_req_valid_i, dbg_we_i, dbg_addr_i, dbg_wdata_i, dbg_resp_ready_i,
    output core_idle_i, bus_gnt_i, bus_rvalid_i, bus_rdata_i, bus_err_i,
    input  dbg_req_ready_o, dbg_resp_valid_o, dbg_resp_rdata_o, dbg_resp_err_o,
    input  core_hold_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o
  );

endinterface

// File: rtl/jtag_bus_timeout.sv
// rtl/jtag_bus_timeout.sv - per-state wait counter flagging the last permitted cycle
module jtag_bus_timeout #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  // Fires in the TIMEOUT-th cycle of a state so the error response lands TIMEOUT cycles after entry
  assign expired = en && (cnt == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/jtag_bus_bridge.sv
// rtl/jtag_bus_bridge.sv - turns one debug memory word access into one system-bus transaction
module jtag_bus_bridge
  import jtag_bus_bridge_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = DEF_TO_W
) (
  input logic               clk,
  input logic               rst_n,
  jtag_bus_bridge_if.slave  io
);

  state_e            state;
  err_code_e         err_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              ready_q;
  logic              hold_q;
  logic              req_q;
  logic              resp_valid_q;

  logic              advance;
  logic              to_en;
  logic              to_expired;

  // Any state exit restarts the wait counter for the state being entered
  always_comb begin
    advance = 1'b0;
    case (state)
      ST_IDLE: advance = io.dbg_req_valid_i;
      ST_HOLD: advance = io.core_idle_i || to_expired;
      ST_REQ:  advance = io.bus_gnt_i || to_expired;
      ST_WAIT: advance = io.bus_rvalid_i || to_expired;
      ST_RESP: advance = io.dbg_resp_ready_i;
      default: advance = 1'b1;
    endcase
  end

  assign to_en = (state == ST_HOLD) || (state == ST_REQ) || (state == ST_WAIT);

  jtag_bus_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (advance),
    .en      (to_en),
    .expired (to_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      err_q        <= ERR_NONE;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      ready_q      <= 1'b1;
      hold_q       <= 1'b0;
      req_q        <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (io.dbg_req_valid_i) begin
            we_q    <= io.dbg_we_i;
            addr_q  <= io.dbg_addr_i;
            wdata_q <= io.dbg_wdata_i;
            ready_q <= 1'b0;
            if (!is_word_aligned(io.dbg_addr_i[1:0])) begin
              state        <= ST_RESP;
              resp_valid_q <= 1'b1;
              err_q        <= ERR_MISALIGN;
              rdata_q      <= '0;
            end else begin
              state  <= ST_HOLD;
              hold_q <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (io.core_idle_i) begin
            state <= ST_REQ;
            req_q <= 1'b1;
          end else if (to_expired) begin
            state        <= ST_RESP;
            resp_valid_q <= 1'b1;
            err_q        <= ERR_TIMEOUT;
            rdata_q      <= '0;
          end
        end
        ST_REQ: begin
          if (io.bus_gnt_i) begin
            state <= ST_WAIT;
            req_q <= 1'b0;
          end else if (to_expired) begin
            state        <= ST_RESP;
            req_q        <= 1'b0;
            resp_valid_q <= 1'b1;
            err_q        <= ERR_TIMEOUT;
            rdata_q      <= '0;
          end
        end
        ST_WAIT: begin
          // A genuine response beats a timeout landing in the same cycle
          if (io.bus_rvalid_i) begin
            state        <= ST_RESP;
            resp_valid_q <= 1'b1;
            err_q        <= io.bus_err_i ? ERR_BUS : ERR_NONE;
            rdata_q      <= (io.bus_err_i || we_q) ? '0 : io.bus_rdata_i;
          end else if (to_expired) begin
            state        <= ST_RESP;
            resp_valid_q <= 1'b1;
            err_q        <= ERR_TIMEOUT;
            rdata_q      <= '0;
          end
        end
        ST_RESP: begin
          if (io.dbg_resp_ready_i) begin
            state        <= ST_IDLE;
            resp_valid_q <= 1'b0;
            hold_q       <= 1'b0;
            ready_q      <= 1'b1;
            err_q        <= ERR_NONE;
            rdata_q      <= '0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          resp_valid_q <= 1'b0;
          hold_q       <= 1'b0;
          req_q        <= 1'b0;
          ready_q      <= 1'b1;
          err_q        <= ERR_NONE;
          rdata_q      <= '0;
        end
      endcase
    end
  end

  assign io.dbg_req_ready_o  = ready_q;
  assign io.dbg_resp_valid_o = resp_valid_q;
  assign io.dbg_resp_rdata_o = rdata_q;
  assign io.dbg_resp_err_o   = (err_q != ERR_NONE);
  assign io.core_hold_o      = hold_q;
  assign io.bus_req_o        = req_q;
  assign io.bus_we_o         = we_q;
  assign io.bus_addr_o       = addr_q;
  assign io.bus_wdata_o      = wdata_q;

endmodule

// File: tb/tb_jtag_bus_bridge.sv
// tb/tb_jtag_bus_bridge.sv - randomized self-checking bench for jtag_bus_bridge
module tb_jtag_bus_bridge;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 255;
  localparam int TO_W    = 8;
  localparam int NEVER   = 100000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  jtag_bus_bridge_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

  jtag_bus_bridge #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bif.slave)
  );

  task automatic quiet_inputs();
    bif.dbg_req_valid_i  = 1'b0;
    bif.dbg_we_i         = 1'b0;
    bif.dbg_addr_i       = '0;
    bif.dbg_wdata_i      = '0;
    bif.dbg_resp_ready_i = 1'b0;
    bif.core_idle_i      = 1'b0;
    bif.bus_gnt_i        = 1'b0;
    bif.bus_rvalid_i     = 1'b0;
    bif.bus_rdata_i      = '0;
    bif.bus_err_i        = 1'b0;
  endtask

  // Reference: cycle of resp_valid (accept = cycle 0) and response contents from the protocol rules
  function automatic void model(input logic we, input logic [31:0] addr, input int idle_dly,
                                input int gnt_dly, input int rv_dly, input logic [31:0] bdata,
                                input logic berr, output int e_resp, output logic e_err,
                                output logic [31:0] e_rdata, output int e_req, output logic e_hold);
    int t;
    e_rdata = 32'h0;
    e_err   = 1'b1;
    e_req   = 0;
    if (addr[1:0] != 2'b00) begin
      e_resp = 1;
      e_hold = 1'b0;
      return;
    end
    e_hold = 1'b1;
    t = 1;
    if (idle_dly > TIMEOUT - 1) begin
      e_resp = t + TIMEOUT;
      return;
    end
    t = t + idle_dly + 1;
    if (gnt_dly > TIMEOUT - 1) begin
      e_resp = t + TIMEOUT;
      e_req  = TIMEOUT;
      return;
    end
    e_req = gnt_dly + 1;
    t = t + gnt_dly + 1;
    if (rv_dly - 1 > TIMEOUT - 1) begin
      e_resp = t + TIMEOUT;
      return;
    end
    e_resp  = t + rv_dly;
    e_err   = berr;
    e_rdata = (berr || we) ? 32'h0 : bdata;
  endfunction

  // Drives one request from IDLE and plays core, arbiter and DM around it; call at posedge+1
  task automatic run_txn(input string name, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int idle_dly, input int gnt_dly,
                         input int rv_dly, input logic [31:0] bdata, input logic berr,
                         input int ready_dly, input logic spur);
    int          e_resp, e_req;
    logic        e_err, e_hold;
    logic [31:0] e_rdata;
    int          cyc = 0;
    int          req_cnt = 0;
    int          gnt_cyc = -1;
    int          resp_cyc = -1;
    int          held = 0;
    logic        hold_seen = 1'b0;
    logic        done = 1'b0;
    logic [31:0] r0 = '0;
    logic        e0 = 1'b0;
    logic        g_we = 1'b0;
    logic [31:0] g_addr = '0;
    logic [31:0] g_wdata = '0;

    model(we, addr, idle_dly, gnt_dly, rv_dly, bdata, berr, e_resp, e_err, e_rdata, e_req, e_hold);

    n_total++;
    if (bif.dbg_req_ready_o !== 1'b1) $display("FAIL %s ready_before: got %b want 1", name, bif.dbg_req_ready_o);
    else n_pass++;

    bif.dbg_req_valid_i = 1'b1;
    bif.dbg_we_i        = we;
    bif.dbg_addr_i      = addr;
    bif.dbg_wdata_i     = wdata;
    @(posedge clk); #1;
    cyc = 1;
    while (!done && cyc < 600) begin
      // Extra requests while busy must be ignored; payload scrambled to prove it was latched
      bif.dbg_req_valid_i = 1'($urandom);
      bif.dbg_we_i        = 1'($urandom);
      bif.dbg_addr_i      = $urandom;
      bif.dbg_wdata_i     = $urandom;
      if (bif.core_hold_o === 1'b1) hold_seen = 1'b1;
      bif.core_idle_i  = (cyc >= 1 + idle_dly);
      bif.bus_gnt_i    = 1'b0;
      bif.bus_rvalid_i = 1'b0;
      bif.bus_err_i    = 1'b0;
      bif.bus_rdata_i  = $urandom;
      if (bif.bus_req_o === 1'b1) begin
        if (req_cnt == gnt_dly) begin
          bif.bus_gnt_i = 1'b1;
          gnt_cyc = cyc;
          g_we    = bif.bus_we_o;
          g_addr  = bif.bus_addr_o;
          g_wdata = bif.bus_wdata_o;
          if (spur) begin
            bif.bus_rvalid_i = 1'b1;
            bif.bus_err_i    = 1'b1;
          end
        end
        req_cnt++;
      end
      if (gnt_cyc >= 0 && cyc == gnt_cyc + rv_dly) begin
        bif.bus_rvalid_i = 1'b1;
        bif.bus_rdata_i  = bdata;
        bif.bus_err_i    = berr;
      end
      if (bif.dbg_resp_valid_o === 1'b1) begin
        if (resp_cyc < 0) begin
          resp_cyc = cyc;
          r0 = bif.dbg_resp_rdata_o;
          e0 = bif.dbg_resp_err_o;
        end else begin
          n_total++;
          if (bif.dbg_resp_rdata_o !== r0 || bif.dbg_resp_err_o !== e0)
            $display("FAIL %s resp_stable: got %h/%b want %h/%b", name, bif.dbg_resp_rdata_o,
                     bif.dbg_resp_err_o, r0, e0);
          else n_pass++;
        end
        bif.dbg_resp_ready_i = (held >= ready_dly);
        if (held >= ready_dly) done = 1'b1;
        held++;
      end else begin
        bif.dbg_resp_ready_i = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    quiet_inputs();

    n_total++;
    if (!done) $display("FAIL %s no_response: got none within %0d cycles want cycle %0d", name, cyc, e_resp);
    else n_pass++;
    n_total++;
    if (resp_cyc !== e_resp) $display("FAIL %s resp_latency: got %0d want %0d", name, resp_cyc, e_resp);
    else n_pass++;
    n_total++;
    if (e0 !== e_err || r0 !== e_rdata)
      $display("FAIL %s resp_data: got %h/%b want %h/%b", name, r0, e0, e_rdata, e_err);
    else n_pass++;
    n_total++;
    if (req_cnt !== e_req) $display("FAIL %s bus_req_cycles: got %0d want %0d", name, req_cnt, e_req);
    else n_pass++;
    n_total++;
    if (hold_seen !== e_hold) $display("FAIL %s core_hold_seen: got %b want %b", name, hold_seen, e_hold);
    else n_pass++;
    if (gnt_cyc >= 0) begin
      n_total++;
      if (g_we !== we || g_addr !== addr || g_wdata !== wdata)
        $display("FAIL %s bus_addr_phase: got %b/%h/%h want %b/%h/%h", name, g_we, g_addr, g_wdata,
                 we, addr, wdata);
      else n_pass++;
    end
    n_total++;
    if (bif.dbg_resp_valid_o !== 1'b0 || bif.dbg_req_ready_o !== 1'b1 || bif.core_hold_o !== 1'b0 ||
        bif.bus_req_o !== 1'b0)
      $display("FAIL %s back_to_idle: got valid=%b ready=%b hold=%b req=%b want 0/1/0/0", name,
               bif.dbg_resp_valid_o, bif.dbg_req_ready_o, bif.core_hold_o, bif.bus_req_o);
    else n_pass++;
  endtask

  task automatic check_idle_outputs(input string name);
    n_total++;
    if (bif.dbg_req_ready_o !== 1'b1 || bif.dbg_resp_valid_o !== 1'b0 || bif.dbg_resp_err_o !== 1'b0 ||
        bif.core_hold_o !== 1'b0 || bif.bus_req_o !== 1'b0 || bif.bus_we_o !== 1'b0)
      $display("FAIL %s ctrl_outputs: got ready=%b valid=%b err=%b hold=%b req=%b we=%b want 1/0/0/0/0/0",
               name, bif.dbg_req_ready_o, bif.dbg_resp_valid_o, bif.dbg_resp_err_o, bif.core_hold_o,
               bif.bus_req_o, bif.bus_we_o);
    else n_pass++;
    n_total++;
    if (bif.dbg_resp_rdata_o !== '0 || bif.bus_addr_o !== '0 || bif.bus_wdata_o !== '0)
      $display("FAIL %s data_outputs: got rdata=%h addr=%h wdata=%h want 0", name,
               bif.dbg_resp_rdata_o, bif.bus_addr_o, bif.bus_wdata_o);
    else n_pass++;
  endtask

  task automatic test_reset();
    quiet_inputs();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    run_txn("read", 1'b0, 32'h0000_0100, $urandom, 0, 0, 1, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
  endtask

  task automatic test_write();
    run_txn("write", 1'b1, 32'h0000_0200, 32'h1234_5678, 0, 0, 1, $urandom, 1'b0, 0, 1'b0);
  endtask

  task automatic test_misaligned();
    run_txn("misaligned", 1'b0, 32'h0000_0102, $urandom, 0, 0, 1, $urandom, 1'b0, 0, 1'b0);
  endtask

  task automatic test_timeout();
    run_txn("gnt_timeout", 1'b0, 32'h0000_0400, $urandom, 0, NEVER, 1, $urandom, 1'b0, 0, 1'b0);
    // A late bus response reaching an idle bridge must not create a response
    bif.bus_rvalid_i = 1'b1;
    bif.bus_rdata_i  = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bif.bus_rvalid_i = 1'b0;
    @(posedge clk); #1;
    n_total++;
    if (bif.dbg_resp_valid_o !== 1'b0 || bif.dbg_req_ready_o !== 1'b1)
      $display("FAIL late_rvalid: got valid=%b ready=%b want 0/1", bif.dbg_resp_valid_o, bif.dbg_req_ready_o);
    else n_pass++;
    run_txn("hold_timeout", 1'b1, 32'h0000_0500, $urandom, NEVER, 0, 1, $urandom, 1'b0, 0, 1'b0);
  endtask

  task automatic test_core_stall_bus_err();
    run_txn("stall_bus_err", 1'b0, 32'h0000_0600, $urandom, 10, 2, 3, 32'hFFFF_FFFF, 1'b1, 0, 1'b0);
  endtask

  task automatic test_resp_backpressure();
    run_txn("backpressure", 1'b0, 32'h0000_0700, $urandom, 1, 1, 2, $urandom, 1'b0, 20, 1'b1);
  endtask

  task automatic test_reset_in_wait();
    int waited = 0;
    bif.dbg_req_valid_i = 1'b1;
    bif.dbg_we_i        = 1'b0;
    bif.dbg_addr_i      = 32'h0000_0300;
    @(posedge clk); #1;
    bif.dbg_req_valid_i = 1'b0;
    bif.core_idle_i     = 1'b1;
    while (bif.bus_req_o !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    n_total++;
    if (bif.bus_req_o !== 1'b1) $display("FAIL rst_wait reach_req: got req=%b want 1", bif.bus_req_o);
    else n_pass++;
    bif.bus_gnt_i = 1'b1;
    @(posedge clk); #1;
    bif.bus_gnt_i = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_wait_async");
    bif.bus_rvalid_i = 1'b1;
    bif.bus_rdata_i  = 32'h5555_AAAA;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    bif.bus_rvalid_i = 1'b0;
    @(posedge clk); #1;
    check_idle_outputs("rst_wait_after");
    quiet_inputs();
  endtask

  task automatic test_random_back_to_back();
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) a = a | 32'($urandom_range(1, 3));
      run_txn($sformatf("rand%0d", i), 1'($urandom), a, $urandom, $urandom_range(0, 5),
              $urandom_range(0, 5), $urandom_range(1, 4), $urandom, 1'($urandom_range(0, 3) == 0),
              $urandom_range(0, 3), 1'($urandom));
    end
  endtask

  initial begin
    quiet_inputs();
    test_reset();
    test_read();
    test_write();
    test_misaligned();
    test_timeout();
    test_core_stall_bus_err();
    test_resp_backpressure();
    test_reset_in_wait();
    test_random_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
